lsu_mem_if: RTL and testbench

LSU_MEM_IF -- requirements
Module: lsu_mem_if

---
 rtl/lsu_mem_if.sv | 121 ++++++++++++
 tb/tb_lsu_mem_if.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Load/store unit to data-memory port bridge.
// Accepts one pipeline request at a time, drives the memory data port until
// the memory signals completion (or the wait counter expires), then presents
// a one-cycle response to the pipeline.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_BITS = 8
) (
    input  logic        MEM_CLK,
    input  logic        RST,
    input  logic        REQ_RD,
    input  logic        REQ_WR,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_DATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2,
    input  logic        memValid2,
    output logic        STALL,
    output logic        RESP_VALID,
    output logic [31:0] RESP_DATA,
    output logic        MISALIGN,
    output logic        TIMEOUT
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [TIMEOUT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = CNT_MAX - 1'b1;
    localparam logic [31:0]             TIMEOUT_DATA = 32'hdead_beef;

    logic [1:0]              state;
    logic                    op_store;
    logic                    timed_out;
    logic [TIMEOUT_BITS-1:0] wait_cnt;

    logic req;
    logic misaligned;
    logic accept;

    // Request decode and alignment check for the request presented in IDLE.
    always_comb begin
        req = REQ_RD | REQ_WR;
        case (REQ_SIZE)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = REQ_ADDR[0];
            2'd2:    misaligned = |REQ_ADDR[1:0];
            default: misaligned = 1'b1;
        endcase
        accept = (state == IDLE) && req && !misaligned;
    end

    // Pipeline-facing and memory-enable outputs decoded from state.
    // The request inputs reach STALL/MISALIGN combinationally, so they are
    // masked while reset is held.
    always_comb begin
        STALL      = !RST && (accept || (state == WAIT));
        MISALIGN   = !RST && (state == IDLE) && req && misaligned;
        MEM_RDEN2  = (state == WAIT) && !op_store;
        MEM_WE2    = (state == WAIT) && op_store;
        RESP_VALID = (state == RESP);
        TIMEOUT    = (state == RESP) && timed_out;
    end

    // Request latch, wait counter, response capture and state sequencing.
    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            op_store  <= 1'b0;
            timed_out <= 1'b0;
            wait_cnt  <= '0;
            MEM_ADDR2 <= '0;
            MEM_DIN2  <= '0;
            MEM_SIZE  <= '0;
            MEM_SIGN  <= 1'b0;
            RESP_DATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        MEM_ADDR2 <= REQ_ADDR;
                        MEM_DIN2  <= REQ_DATA;
                        MEM_SIZE  <= REQ_SIZE;
                        MEM_SIGN  <= REQ_SIGN;
                        op_store  <= REQ_WR;
                        timed_out <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (memValid2) begin
                        RESP_DATA <= op_store ? '0 : MEM_DOUT2;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CNT_LAST) begin
                            RESP_DATA <= TIMEOUT_DATA;
                            timed_out <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: alignment vector table, directed
// multi-cycle sequences, and randomized transactions checked against a
// transaction-level model (expected WAIT count, response data, timeout).
module tb_lsu_mem_if;

    logic        clk;
    logic        rst;
    logic        sel;           // 0: default-parameter DUT, 1: TIMEOUT_BITS=3 DUT
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] mem_dout;
    logic        mem_valid;

    int checks = 0;
    int errors = 0;

    // per-DUT gated inputs and outputs
    logic        a_rd, a_wr, a_valid, b_rd, b_wr, b_valid;
    logic        a_rden, a_we, a_sign, a_stall, a_rvalid, a_mis, a_tout;
    logic        b_rden, b_we, b_sign, b_stall, b_rvalid, b_mis, b_tout;
    logic [31:0] a_addr, a_din, a_rdata, b_addr, b_din, b_rdata;
    logic [1:0]  a_size, b_size;

    // selected outputs
    logic        o_rden, o_we, o_sign, o_stall, o_rvalid, o_mis, o_tout;
    logic [31:0] o_addr, o_din, o_rdata;
    logic [1:0]  o_size;

    assign a_rd    = req_rd & ~sel;
    assign a_wr    = req_wr & ~sel;
    assign a_valid = mem_valid & ~sel;
    assign b_rd    = req_rd & sel;
    assign b_wr    = req_wr & sel;
    assign b_valid = mem_valid & sel;

    lsu_mem_if dut_a (
        .MEM_CLK(clk), .RST(rst), .REQ_RD(a_rd), .REQ_WR(a_wr),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data), .REQ_SIZE(req_size), .REQ_SIGN(req_sign),
        .MEM_RDEN2(a_rden), .MEM_WE2(a_we), .MEM_ADDR2(a_addr), .MEM_DIN2(a_din),
        .MEM_SIZE(a_size), .MEM_SIGN(a_sign), .MEM_DOUT2(mem_dout), .memValid2(a_valid),
        .STALL(a_stall), .RESP_VALID(a_rvalid), .RESP_DATA(a_rdata),
        .MISALIGN(a_mis), .TIMEOUT(a_tout)
    );

    lsu_mem_if #(.TIMEOUT_BITS(3)) dut_b (
        .MEM_CLK(clk), .RST(rst), .REQ_RD(b_rd), .REQ_WR(b_wr),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data), .REQ_SIZE(req_size), .REQ_SIGN(req_sign),
        .MEM_RDEN2(b_rden), .MEM_WE2(b_we), .MEM_ADDR2(b_addr), .MEM_DIN2(b_din),
        .MEM_SIZE(b_size), .MEM_SIGN(b_sign), .MEM_DOUT2(mem_dout), .memValid2(b_valid),
        .STALL(b_stall), .RESP_VALID(b_rvalid), .RESP_DATA(b_rdata),
        .MISALIGN(b_mis), .TIMEOUT(b_tout)
    );

    always_comb begin
        o_rden   = sel ? b_rden   : a_rden;
        o_we     = sel ? b_we     : a_we;
        o_addr   = sel ? b_addr   : a_addr;
        o_din    = sel ? b_din    : a_din;
        o_size   = sel ? b_size   : a_size;
        o_sign   = sel ? b_sign   : a_sign;
        o_stall  = sel ? b_stall  : a_stall;
        o_rvalid = sel ? b_rvalid : a_rvalid;
        o_rdata  = sel ? b_rdata  : a_rdata;
        o_mis    = sel ? b_mis    : a_mis;
        o_tout   = sel ? b_tout   : a_tout;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: alignment rule
    function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd2) return addr[1:0] != 2'b00;
        if (size == 2'd1) return addr[0];
        return 1'b0;
    endfunction

    // One full transaction, started just after a rising edge with the DUT in IDLE.
    // delay = number of WAIT cycles before memValid2 rises (0 = first WAIT cycle).
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size, input logic sign,
                         input int unsigned delay, input logic [31:0] dout);
        int unsigned limit;
        int unsigned nexp;
        logic        store;
        logic        tmo;
        logic [31:0] exp_data;
        limit = sel ? 7 : 255;
        store = wr;
        req_rd = rd; req_wr = wr; req_addr = addr; req_data = data;
        req_size = size; req_sign = sign; mem_dout = dout; mem_valid = 1'b0;
        @(negedge clk);
        if (model_misaligned(size, addr)) begin
            chk1("misalign_pulse", o_mis, 1'b1);
            chk1("misalign_stall", o_stall, 1'b0);
            chk1("misalign_no_access", o_rden | o_we, 1'b0);
            @(posedge clk); #1;
            req_rd = 1'b0; req_wr = 1'b0;
            @(negedge clk);
            chk1("misalign_stays_idle", o_rden | o_we | o_rvalid, 1'b0);
            @(posedge clk); #1;
            return;
        end
        chk1("accept_stall", o_stall, 1'b1);
        chk1("accept_no_misalign", o_mis, 1'b0);
        chk1("accept_no_enable_yet", o_rden | o_we, 1'b0);
        @(posedge clk); #1;
        tmo      = (delay >= limit);
        nexp     = tmo ? limit : delay + 1;
        exp_data = tmo ? 32'hdead_beef : (store ? 32'h0 : dout);
        for (int unsigned c = 0; c < nexp; c++) begin
            mem_valid = (c == delay);
            @(negedge clk);
            chk1("wait_rden", o_rden, !store);
            chk1("wait_we", o_we, store);
            chk1("wait_stall", o_stall, 1'b1);
            chk1("wait_no_resp", o_rvalid, 1'b0);
            chk32("wait_addr", o_addr, addr);
            chk32("wait_din", o_din, data);
            chk32("wait_size_sign", {29'd0, o_size, o_sign}, {29'd0, size, sign});
            @(posedge clk); #1;
        end
        mem_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        @(negedge clk);
        chk1("resp_valid", o_rvalid, 1'b1);
        chk1("resp_stall", o_stall, 1'b0);
        chk1("resp_enables", o_rden | o_we, 1'b0);
        chk32("resp_data", o_rdata, exp_data);
        chk1("resp_timeout", o_tout, tmo);
        chk32("resp_addr_hold", o_addr, addr);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        exp_mis;
        logic        exp_stall;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_6000, 2'd2, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_6002, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_6001, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_6002, 2'd1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_6001, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_6002, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_6003, 2'd0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_6000, 2'd3, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h0000_6004, 2'd1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 32'h0000_6001, 2'd2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_6003, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_6001, 2'd0, 1'b0, 1'b1};

        sel = 1'b0; rst = 1'b1;
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h6000; req_data = 32'h0;
        req_size = 2'd2; req_sign = 1'b0; mem_dout = 32'h0; mem_valid = 1'b1;

        // Reset state, with an aligned request held: nothing may start
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_stall", o_stall, 1'b0);
        chk1("rst_enables", o_rden | o_we, 1'b0);
        chk1("rst_resp_valid", o_rvalid, 1'b0);
        chk1("rst_timeout", o_tout, 1'b0);
        chk32("rst_addr", o_addr, 32'h0);
        chk32("rst_din", o_din, 32'h0);
        chk32("rst_size_sign", {29'd0, o_size, o_sign}, 32'h0);
        chk32("rst_resp_data", o_rdata, 32'h0);
        req_size = 2'd3;
        #1;
        chk1("rst_misalign", o_mis, 1'b0);

        // First request accepted on the first edge after reset release; word load
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(1'b1, 1'b0, 32'h0000_6000, 32'h0, 2'd2, 1'b0, 0, 32'h1234_5678);

        // Combinational alignment / stall table, request withdrawn before the edge
        foreach (tbl[i]) begin
            req_rd = tbl[i].rd; req_wr = tbl[i].wr;
            req_addr = tbl[i].addr; req_size = tbl[i].size;
            #2;
            chk1($sformatf("tbl%0d_misalign", i), o_mis, tbl[i].exp_mis);
            chk1($sformatf("tbl%0d_stall", i), o_stall, tbl[i].exp_stall);
            chk1($sformatf("tbl%0d_enables", i), o_rden | o_we, 1'b0);
            req_rd = 1'b0; req_wr = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1("tbl_still_idle", o_rden | o_we | o_rvalid, 1'b0);
        @(posedge clk); #1;

        // Byte store with completion after 5 WAIT cycles
        do_op(1'b0, 1'b1, 32'h0000_6003, 32'h0000_00AB, 2'd0, 1'b0, 5, 32'hFFFF_FFFF);
        // Misaligned half load and word store
        do_op(1'b1, 1'b0, 32'h0000_6001, 32'h0, 2'd1, 1'b0, 0, 32'h0);
        do_op(1'b0, 1'b1, 32'h0000_6002, 32'h5555_AAAA, 2'd2, 1'b0, 0, 32'h0);
        // Back-to-back: load then rd=wr=1 (treated as store)
        do_op(1'b1, 1'b0, 32'h0000_6010, 32'h0, 2'd2, 1'b1, 0, 32'hCAFE_F00D);
        do_op(1'b1, 1'b1, 32'h0000_6020, 32'h7777_8888, 2'd2, 1'b0, 1, 32'h1111_2222);
        do_op(1'b1, 1'b0, 32'h0000_6030, 32'h0, 2'd1, 1'b1, 2, 32'h5A5A_1234);

        // Reset in the second WAIT cycle aborts the access
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h0000_6040; req_size = 2'd2;
        mem_valid = 1'b0;
        @(negedge clk);
        chk1("abort_accept", o_stall, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("abort_in_wait", o_rden, 1'b1);
        rst = 1'b1;
        #1;
        chk1("abort_enables", o_rden | o_we, 1'b0);
        chk1("abort_stall", o_stall, 1'b0);
        chk32("abort_addr", o_addr, 32'h0);
        chk32("abort_resp_data", o_rdata, 32'h0);
        req_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("abort_no_resp", o_rvalid | o_rden | o_we, 1'b0);
            @(posedge clk); #1;
        end
        do_op(1'b1, 1'b0, 32'h0000_6044, 32'h0, 2'd2, 1'b0, 0, 32'h0BAD_F00D);

        // Randomized transactions on the default-parameter instance
        for (int n = 0; n < 40; n++) begin
            int unsigned k;
            k = $urandom_range(0, 2);
            do_op(k != 1, k != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom);
        end

        // Short-timeout instance: timeout, just-in-time completion, boundary
        sel = 1'b1;
        do_op(1'b1, 1'b0, 32'h0000_7000, 32'h0, 2'd2, 1'b0, 100, 32'h1357_9BDF);
        do_op(1'b1, 1'b0, 32'h0000_7004, 32'h0, 2'd2, 1'b0, 6, 32'h2468_ACE0);
        do_op(1'b0, 1'b1, 32'h0000_7008, 32'h1, 2'd2, 1'b0, 7, 32'h0);
        for (int n = 0; n < 15; n++) begin
            int unsigned k;
            k = $urandom_range(0, 2);
            do_op(k != 1, k != 0, $urandom, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 10), $urandom);
        end
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
